// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Puts the datapath's instruction-fetch and data-access requests onto a single
// single-ported RAM, one access at a time.
//
// Arbitration: data requests win over a waiting fetch. After MAXD consecutive
// data grants made while a fetch was waiting, the fetch is served next.
// Address, store data and access kind are captured at grant. The RAM port is
// driven only from those registers.
//
// Each access ends on ramready, or on a watchdog abort after TIMEOUT cycles.
// An abort sets the sticky err flag and returns 32'hBAD1BAD1 for reads. Every
// access ends with a one-cycle ihit or dhit pulse in the DONE state. All
// outputs come straight from flops.
//
// Parameters
//   TIMEOUT   access cycles without ramready before abort (1..65535)
//   MAXD      data grants allowed in a row while a fetch waits (>= 1)
//
// Ports
//   CLK, nRST                 rising-edge clock, async active-low reset
//   imemREN/imemaddr          fetch request (held until ihit) and address
//   imemload/ihit             fetched word and its completion pulse
//   dmemREN/dmemWEN           data read / write request (held until dhit)
//   dmemaddr/dmemstore        data address and write data
//   dmemload/dhit             read data and its completion pulse
//   ramREN/ramWEN             RAM read / write strobes
//   ramaddr/ramstore          RAM address / write data
//   ramload/ramready          RAM read data and one-cycle completion pulse
//   err                       sticky watchdog flag
// -----------------------------------------------------------------------------
module memory_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int MAXD    = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic [31:0] imemload,
   output logic        ihit,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic [31:0] dmemload,
   output logic        dhit,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready,
   output logic        err
);

   localparam int            SW         = $clog2(MAXD + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAXD);
   localparam logic [SW-1:0] STREAK_ONE = SW'(1);
   localparam logic [15:0]   WD_LAST    = 16'(TIMEOUT - 1);
   localparam logic [31:0]   ABORT_DATA = 32'hBAD1_BAD1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_r;
   state_t        next_state_s;

   logic          data_req_s;
   logic          streak_full_s;
   logic          grant_i_s;
   logic          grant_d_s;
   logic          complete_s;
   logic          abort_s;

   logic          write_r;
   logic          write_next_s;
   logic [SW-1:0] streak_r;
   logic [SW-1:0] streak_next_s;
   logic [15:0]   wd_r;
   logic [15:0]   wd_next_s;

   logic          ramren_r;
   logic          ramwen_r;
   logic          ihit_r;
   logic          dhit_r;
   logic          err_r;
   logic [31:0]   ramaddr_r;
   logic [31:0]   ramstore_r;
   logic [31:0]   imemload_r;
   logic [31:0]   dmemload_r;

   logic          ramren_next_s;
   logic          ramwen_next_s;
   logic          ihit_next_s;
   logic          dhit_next_s;
   logic          err_next_s;
   logic [31:0]   ramaddr_next_s;
   logic [31:0]   ramstore_next_s;
   logic [31:0]   imemload_next_s;
   logic [31:0]   dmemload_next_s;

   assign data_req_s    = dmemREN | dmemWEN;
   assign streak_full_s = (streak_r >= STREAK_MAX);

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: arbitration in IDLE, completion or watchdog abort in
   // the access states.
   always_comb begin
      next_state_s = state_r;
      grant_i_s    = 1'b0;
      grant_d_s    = 1'b0;
      complete_s   = 1'b0;
      abort_s      = 1'b0;
      case (state_r)
         IDLE: begin
            // The guard only holds data back while a fetch is actually
            // waiting. If the fetch vanishes at a full streak, data is
            // still served rather than stalling.
            if (data_req_s && (!streak_full_s || !imemREN)) begin
               next_state_s = DACC;
               grant_d_s    = 1'b1;
            end else if (imemREN) begin
               next_state_s = IACC;
               grant_i_s    = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         IACC, DACC: begin
            // ramready takes priority over a timeout in the same cycle.
            if (ramready) begin
               next_state_s = DONE;
               complete_s   = 1'b1;
            end else if (wd_r == WD_LAST) begin
               next_state_s = DONE;
               abort_s      = 1'b1;
            end else begin
               next_state_s = state_r;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Next values for the streak counter, the watchdog and the latched access kind.
   always_comb begin
      streak_next_s = streak_r;
      wd_next_s     = wd_r;
      write_next_s  = write_r;

      if (grant_i_s) begin
         streak_next_s = '0;
      end else if (grant_d_s) begin
         if (!imemREN) begin
            streak_next_s = '0;
         end else if (streak_full_s) begin
            streak_next_s = STREAK_MAX;
         end else begin
            streak_next_s = streak_r + STREAK_ONE;
         end
      end else begin
         streak_next_s = streak_r;
      end

      if (grant_i_s || grant_d_s) begin
         wd_next_s = 16'd0;
      end else if (((state_r == IACC) || (state_r == DACC)) && (next_state_s == state_r)) begin
         wd_next_s = wd_r + 16'd1;
      end else begin
         wd_next_s = 16'd0;
      end

      if (grant_d_s) begin
         write_next_s = dmemWEN;
      end else begin
         write_next_s = write_r;
      end
   end

   // Streak, watchdog and access-kind registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         streak_r <= '0;
         wd_r     <= 16'd0;
         write_r  <= 1'b0;
      end else begin
         streak_r <= streak_next_s;
         wd_r     <= wd_next_s;
         write_r  <= write_next_s;
      end
   end

   // Output logic: the values every output register takes next, derived from
   // the next state so that strobes line up with the state they belong to.
   always_comb begin
      ramren_next_s   = (next_state_s == IACC) ||
                        ((next_state_s == DACC) && !write_next_s);
      ramwen_next_s   = (next_state_s == DACC) && write_next_s;
      ihit_next_s     = (state_r == IACC) && (complete_s || abort_s);
      dhit_next_s     = (state_r == DACC) && (complete_s || abort_s);
      err_next_s      = err_r | abort_s;

      if (grant_i_s) begin
         ramaddr_next_s = imemaddr;
      end else if (grant_d_s) begin
         ramaddr_next_s = dmemaddr;
      end else begin
         ramaddr_next_s = ramaddr_r;
      end

      if (grant_d_s) begin
         ramstore_next_s = dmemstore;
      end else begin
         ramstore_next_s = ramstore_r;
      end

      imemload_next_s = imemload_r;
      if (state_r == IACC) begin
         if (complete_s) begin
            imemload_next_s = ramload;
         end else if (abort_s) begin
            imemload_next_s = ABORT_DATA;
         end else begin
            imemload_next_s = imemload_r;
         end
      end else begin
         imemload_next_s = imemload_r;
      end

      // A write leaves dmemload untouched, even on abort.
      dmemload_next_s = dmemload_r;
      if ((state_r == DACC) && !write_r) begin
         if (complete_s) begin
            dmemload_next_s = ramload;
         end else if (abort_s) begin
            dmemload_next_s = ABORT_DATA;
         end else begin
            dmemload_next_s = dmemload_r;
         end
      end else begin
         dmemload_next_s = dmemload_r;
      end
   end

   // Output registers. Reset clears the strobes straight away, even mid-access.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ramren_r   <= 1'b0;
         ramwen_r   <= 1'b0;
         ihit_r     <= 1'b0;
         dhit_r     <= 1'b0;
         err_r      <= 1'b0;
         ramaddr_r  <= 32'd0;
         ramstore_r <= 32'd0;
         imemload_r <= 32'd0;
         dmemload_r <= 32'd0;
      end else begin
         ramren_r   <= ramren_next_s;
         ramwen_r   <= ramwen_next_s;
         ihit_r     <= ihit_next_s;
         dhit_r     <= dhit_next_s;
         err_r      <= err_next_s;
         ramaddr_r  <= ramaddr_next_s;
         ramstore_r <= ramstore_next_s;
         imemload_r <= imemload_next_s;
         dmemload_r <= dmemload_next_s;
      end
   end

   assign ramREN   = ramren_r;
   assign ramWEN   = ramwen_r;
   assign ramaddr  = ramaddr_r;
   assign ramstore = ramstore_r;
   assign ihit     = ihit_r;
   assign dhit     = dhit_r;
   assign imemload = imemload_r;
   assign dmemload = dmemload_r;
   assign err      = err_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Testbench for memory_arbiter (TIMEOUT=8, MAXD=4). Its parts, in order:
//   - a table of single transactions with expected strobes, data and
//     hit latency;
//   - hand-written sequences for simultaneous requests, starvation,
//     watchdog abort and reset mid-access;
//   - randomized rounds. A transaction-level model orders the hits from
//     the arbitration rule. A RAM responder answers with random latency and
//     also sends stray ramready pulses outside accesses.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

   localparam int          TIMEOUT = 8;
   localparam int          MAXD    = 4;
   localparam logic [31:0] ABORT   = 32'hBAD1_BAD1;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN, dmemREN, dmemWEN, ramready;
   logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
   logic [31:0] imemload, dmemload, ramaddr, ramstore;
   logic        ihit, dhit, ramREN, ramWEN, err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        ireq;
      logic        dren;
      logic        dwen;
      logic [31:0] addr;
      logic [31:0] store;
      logic [31:0] rload;
      int          lat;
      logic        exp_ren;
      logic        exp_wen;
      logic        exp_i;
      logic [31:0] exp_load;
      int          exp_cyc;
   } vec_t;

   typedef struct {
      logic        is_i;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
   } op_t;

   vec_t        vecs [7];
   op_t         expq [$];
   op_t         dq   [$];
   op_t         iop;
   op_t         op;
   logic        ipend      = 1'b0;
   logic        junk_ready = 1'b0;
   logic        err_model  = 1'b0;
   logic [31:0] dmodel     = 32'd0;
   int          streak_m   = 0;
   int          lat_lo     = 0;
   int          lat_hi     = 3;
   int          gap, nd, w;
   logic [1:0]  kind;

   memory_arbiter #(.TIMEOUT(TIMEOUT), .MAXD(MAXD)) dut (
      .CLK(CLK), .nRST(nRST),
      .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ramREN"},   ramREN,   32'd0);
      check({tag, "_ramWEN"},   ramWEN,   32'd0);
      check({tag, "_ramaddr"},  ramaddr,  32'd0);
      check({tag, "_ramstore"}, ramstore, 32'd0);
      check({tag, "_imemload"}, imemload, 32'd0);
      check({tag, "_dmemload"}, dmemload, 32'd0);
      check({tag, "_ihit"},     ihit,     32'd0);
      check({tag, "_dhit"},     dhit,     32'd0);
      check({tag, "_err"},      err,      32'd0);
   endtask

   task automatic clear_inputs();
      imemREN   = 1'b0;
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      imemaddr  = 32'd0;
      dmemaddr  = 32'd0;
      dmemstore = 32'd0;
   endtask

   task automatic drive_reqs();
      imemREN  = ipend;
      imemaddr = iop.addr;
      if (dq.size() > 0) begin
         dmemREN   = dq[0].ren;
         dmemWEN   = dq[0].wen;
         dmemaddr  = dq[0].addr;
         dmemstore = dq[0].store;
      end else begin
         dmemREN   = 1'b0;
         dmemWEN   = 1'b0;
         dmemaddr  = 32'd0;
         dmemstore = 32'd0;
      end
   endtask

   // Expected service order: data first unless MAXD data grants have already
   // gone by while this fetch waited.
   task automatic plan();
      logic ip;
      int   k;
      ip = ipend;
      k  = 0;
      while (ip || k < dq.size()) begin
         if (k < dq.size() && (streak_m < MAXD || !ip)) begin
            expq.push_back(dq[k]);
            streak_m = ip ? ((streak_m < MAXD) ? streak_m + 1 : MAXD) : 0;
            k++;
         end else begin
            expq.push_back(iop);
            streak_m = 0;
            ip = 1'b0;
         end
      end
   endtask

   // One table transaction, issued from IDLE.
   task automatic run_vec(input vec_t v);
      int   n, acc;
      logic seen;
      imemREN   = v.ireq;
      imemaddr  = v.addr;
      dmemREN   = v.dren;
      dmemWEN   = v.dwen;
      dmemaddr  = v.addr;
      dmemstore = v.store;
      n = 0; acc = 0; seen = 1'b0;
      while (!seen && n < 30) begin
         @(negedge CLK);
         n++;
         ramready = 1'b0;
         if (ramREN || ramWEN) begin
            if (acc == 0) begin
               check("vec_ramREN",  ramREN,  v.exp_ren);
               check("vec_ramWEN",  ramWEN,  v.exp_wen);
               check("vec_ramaddr", ramaddr, v.addr);
               if (v.exp_wen) check("vec_ramstore", ramstore, v.store);
            end
            if (acc == v.lat) begin
               ramready = 1'b1;
               ramload  = v.rload;
            end
            acc++;
         end
         if (ihit || dhit) begin
            seen = 1'b1;
            check("vec_hit_cycle", n, v.exp_cyc);
            check("vec_ihit", ihit, v.exp_i);
            check("vec_dhit", dhit, !v.exp_i);
            if (v.exp_i) begin
               check("vec_imemload", imemload, v.exp_load);
            end else begin
               check("vec_dmemload", dmemload, v.exp_load);
               dmodel = v.exp_load;
            end
            clear_inputs();
         end
      end
      if (!seen) begin
         check("vec_no_hit", 32'd0, 32'd1);
         clear_inputs();
      end
      @(negedge CLK);
      ramready = 1'b0;
      check("vec_idle_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
      check("vec_idle_hits",    {30'd0, ihit, dhit},     32'd0);
   endtask

   // Requesters plus RAM responder. Each access is checked against the head of
   // expq, and each hit against the model's data and err.
   task automatic serve(input int budget);
      int          n, acc, lat, last_acc;
      logic        got_ready, exp_wen;
      logic [31:0] given;
      op_t         e;
      n = 0; acc = 0; lat = 0; last_acc = 0;
      got_ready = 1'b0; given = 32'd0;
      drive_reqs();
      while (expq.size() > 0 && n < budget) begin
         @(negedge CLK);
         n++;
         ramready = 1'b0;
         check("excl_hits",    ihit & dhit,     32'd0);
         check("excl_strobes", ramREN & ramWEN, 32'd0);
         if (ramREN || ramWEN) begin
            if (acc == 0) begin
               e = expq[0];
               exp_wen = !e.is_i && e.wen;
               check("acc_ramWEN",  ramWEN,  exp_wen);
               check("acc_ramREN",  ramREN,  !exp_wen);
               check("acc_ramaddr", ramaddr, e.addr);
               if (exp_wen) check("acc_ramstore", ramstore, e.store);
               lat = $urandom_range(lat_hi, lat_lo);
               got_ready = 1'b0;
            end
            if (acc == lat) begin
               given     = $urandom;
               ramready  = 1'b1;
               ramload   = given;
               got_ready = 1'b1;
            end
            acc++;
         end else begin
            if (acc > 0) last_acc = acc;
            acc = 0;
            if (junk_ready && $urandom_range(3, 0) == 0) begin
               ramready = 1'b1;
               ramload  = $urandom;
            end
         end
         if (ihit || dhit) begin
            e = expq.pop_front();
            check("hit_ihit", ihit, e.is_i);
            check("hit_dhit", dhit, !e.is_i);
            check("hit_access_cycles", last_acc, got_ready ? lat + 1 : TIMEOUT);
            if (!got_ready) err_model = 1'b1;
            check("hit_err", err, err_model);
            if (e.is_i) begin
               check("hit_imemload", imemload, got_ready ? given : ABORT);
               ipend = 1'b0;
            end else begin
               if (!e.wen) dmodel = got_ready ? given : ABORT;
               check("hit_dmemload", dmemload, dmodel);
               if (dq.size() > 0) void'(dq.pop_front());
            end
            drive_reqs();
         end
      end
      ramready = 1'b0;
      if (expq.size() > 0) begin
         check("serve_budget", expq.size(), 32'd0);
         expq.delete();
      end
   endtask

   initial begin
      nRST     = 1'b1;
      ramready = 1'b0;
      ramload  = 32'd0;
      clear_inputs();
      iop = '{1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
      #2 nRST = 1'b0;
      repeat (2) @(negedge CLK);
      check_zero("reset");
      nRST = 1'b1;
      @(negedge CLK);
      check_zero("post_reset");

      // ireq dren dwen addr store rload lat exp_ren exp_wen exp_i exp_load exp_cyc
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C22_0004, 1, 1'b1, 1'b0, 1'b1, 32'h8C22_0004, 3};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_1234, 0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 2};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 4};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 2};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'h0, 32'hA5A5_5A5A, 3, 1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A, 5};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0, 7, 1'b0, 1'b1, 1'b0, 32'hA5A5_5A5A, 9};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 7, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 9};
      for (int i = 0; i < 7; i++) run_vec(vecs[i]);
      check("err_after_table", err, 32'd0);

      // Simultaneous fetch and data read: data goes first.
      ipend = 1'b1;
      iop   = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0};
      op    = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'd0};
      dq.push_back(op);
      expq.push_back(op);
      expq.push_back(iop);
      serve(60);

      // Starvation guard: four data hits, then the fetch, then data again.
      ipend = 1'b1;
      iop   = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'd0};
      for (int k = 0; k < 6; k++) begin
         op = '{1'b0, 1'b1, k[0], 32'h0000_1000 + 32'(k * 4), 32'hC0DE_0000 + 32'(k)};
         dq.push_back(op);
      end
      for (int k = 0; k < 4; k++) expq.push_back(dq[k]);
      expq.push_back(iop);
      expq.push_back(dq[4]);
      expq.push_back(dq[5]);
      serve(200);
      streak_m = 0;

      // Watchdog: a data read and a fetch are both aborted, then a normal
      // write runs while err stays set.
      lat_lo = 100; lat_hi = 100;
      op = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'd0};
      dq.push_back(op);
      expq.push_back(op);
      serve(40);
      ipend = 1'b1;
      iop   = '{1'b1, 1'b1, 1'b0, 32'h0000_0340, 32'd0};
      expq.push_back(iop);
      serve(40);
      lat_lo = 0; lat_hi = 3;
      op = '{1'b0, 1'b0, 1'b1, 32'h0000_0380, 32'h5555_AAAA};
      dq.push_back(op);
      expq.push_back(op);
      serve(40);
      check("err_sticky", err, 32'd1);

      // Reset in the middle of a data read.
      op = '{1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'd0};
      dq.push_back(op);
      drive_reqs();
      w = 0;
      while (!ramREN && w < 10) begin
         @(negedge CLK);
         w++;
      end
      check("rst_mid_ramREN_before", ramREN, 32'd1);
      nRST = 1'b0;
      #1;
      check("rst_mid_ramREN_async", ramREN, 32'd0);
      dq.delete();
      drive_reqs();
      check_zero("rst_mid");
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      check_zero("rst_release");
      err_model = 1'b0;
      dmodel    = 32'd0;
      streak_m  = 0;
      op = '{1'b0, 1'b1, 1'b0, 32'h0000_0504, 32'd0};
      dq.push_back(op);
      expq.push_back(op);
      serve(40);

      // Random rounds with stray ramready pulses outside accesses.
      junk_ready = 1'b1;
      for (int r = 0; r < 40; r++) begin
         gap = $urandom_range(2, 0);
         for (int g = 0; g < gap; g++) @(negedge CLK);
         ipend = ($urandom_range(3, 0) != 0);
         iop   = '{1'b1, 1'b1, 1'b0, $urandom, 32'd0};
         nd    = $urandom_range(7, 0);
         dq.delete();
         for (int k = 0; k < nd; k++) begin
            kind = 2'($urandom_range(3, 1));
            op   = '{1'b0, kind[0], kind[1], $urandom, $urandom};
            dq.push_back(op);
         end
         plan();
         serve(400);
      end
      junk_ready = 1'b0;
      check("err_end", err, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequences the datapath's instruction-fetch and data-access requests onto a single-ported RAM. Sits between the datapath cache-side signals (imem*/dmem*, ihit/dhit) and the RAM port. Grants one access at a time under data-priority with a starvation guard, tracks RAM completion, returns load data with one-cycle hit pulses, and aborts hung accesses with a watchdog.

## Interface
- TIMEOUT, 255: cycles in an access state without ramready before abort (1..65535)
- MAXD, 4: consecutive data grants allowed while an instruction request waits (≥1)
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  instruction read request; held until ihit
- imemaddr  in  32  instruction address
- imemload  out  32  fetched instruction, valid with ihit
- ihit  out  1  one-cycle instruction completion pulse
- dmemREN  in  1  data read request; held until dhit
- dmemWEN  in  1  data write request; held until dhit; wins over dmemREN if both high
- dmemaddr  in  32  data address
- dmemstore  in  32  write data
- dmemload  out  32  read data, valid with dhit
- dhit  out  1  one-cycle data completion pulse
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid with ramready
- ramready  in  1  RAM completion, one-cycle pulse
- err  out  1  sticky watchdog flag

## Operation
- States: IDLE, IACC, DACC, DONE.
- IDLE: sample requests. Data pending (dmemREN|dmemWEN) and streak<MAXD → DACC; else imemREN → IACC; else stay. Data pending with streak==MAXD and imemREN high → IACC.
- On grant, latch address, store data, and read/write kind into registers; RAM outputs drive only from these registers, never from live inputs.
- IACC: ramREN=1, ramaddr=latched imemaddr. DACC: ramWEN=1 for writes, else ramREN=1; ramaddr/ramstore from latches.
- On ramready in IACC/DACC: capture ramload into imemload (IACC) or dmemload (DACC read; unchanged on write); go DONE.
- DONE: ihit or dhit high for exactly this cycle; RAM strobes low; → IDLE. The following IDLE sees requester-updated inputs.
- Streak counter: +1 per data grant while imemREN high, saturating at MAXD; cleared on any instruction grant or when imemREN is low at a data grant.
- Watchdog: 16-bit counter cleared on entering IACC/DACC, +1 per cycle there. At TIMEOUT without ramready: err←1 (sticky), load register ← 32'hBAD1BAD1 (for reads), → DONE with normal hit. ramready on the same cycle as the timeout wins (normal completion, no err).
- ramready outside IACC/DACC is ignored.
- Request dropped mid-access: the access completes and the hit still pulses; no cancellation.
- Address arithmetic: pass-through, no alignment check.

## Timing
- Reset (async, immediate): state IDLE, all strobes 0, ramaddr/ramstore 0, imemload/dmemload 0, ihit/dhit 0, err 0, counters 0. Reset mid-access drops RAM strobes in the same cycle.
- Request visible at edge k (IDLE) → strobes high from k+1 → ramready at cycle k+1+L (L≥0) → hit in cycle k+2+L → IDLE at k+3+L. Minimum request-to-hit latency is 2 cycles; minimum back-to-back spacing is 3 cycles.
- All outputs are registered; no combinational input-to-output path.
- ihit and dhit are never high together; ramREN and ramWEN are never high together.

## Test plan
- Single fetch: imemREN, addr 0x40, ramready in the 2nd IACC cycle with ramload 0x8C220004 → ramREN with ramaddr 0x40; ihit one cycle with imemload 0x8C220004; back to IDLE.
- Simultaneous requests: imemREN and dmemREN at 0x100 with ramload 0x1234 → DACC first, dhit/dmemload 0x1234, then IACC and ihit.
- Write: dmemWEN and dmemREN, addr 0x200, store 0xDEADBEEF → ramWEN only, ramstore 0xDEADBEEF, dhit, dmemload unchanged.
- Starvation with MAXD=4: data held continuously plus imemREN → exactly 4 dhits, then ihit, then data resumes.
- Watchdog with TIMEOUT=8: ramready withheld on a read → after 8 DACC cycles err=1, dhit with dmemload 0xBAD1BAD1; err persists until nRST.
- Reset mid-DACC: nRST low while ramREN is high → ramREN drops asynchronously, all outputs are 0 after release, and the next request is served normally.
